// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx
//   Serialises the 15-bit signed nanomig DAC words as Philips I2S. BCLK and
//   LRCK come from a fractional phase accumulator clocked by clk_sys, so the
//   whole block lives in the clk_sys domain. BCLK runs at 64*SAMPLE_HZ with
//   32-bit slots per channel. Each word is 16 bits, MSB first, starting one
//   BCLK after the LRCK edge, and is followed by zero padding.
//
//   Optional build macro: AUDIO_I2S_CROSSFEED_EN. When defined, each latched
//   pair is mixed 3:1 with the opposite channel to soften hard panning.
//
// Ports
//   clk_sys        system clock
//   reset          asynchronous reset, active-high
//   audio_left     signed left sample (15 bit)
//   audio_right    signed right sample (15 bit)
//   mute           1 = zero samples from the next frame on
//   i2s_bclk       bit clock
//   i2s_lrck       word select (0 = left, 1 = right)
//   i2s_sdata      serial data, MSB first
//   sample_strobe  one-clk pulse when a new L/R pair is latched
module audio_i2s_tx #(
  parameter int CLK_HZ    = 28687500,
  parameter int SAMPLE_HZ = 48000,
  parameter int ACC_W     = 32
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic signed [14:0]  audio_left,
  input  logic signed [14:0]  audio_right,
  input  logic                mute,
  output logic                i2s_bclk,
  output logic                i2s_lrck,
  output logic                i2s_sdata,
  output logic                sample_strobe
);

  // Two accumulator wraps per BCLK period.
  localparam logic [ACC_W:0] INC = (ACC_W+1)'(128 * SAMPLE_HZ);
  localparam logic [ACC_W:0] LIM = (ACC_W+1)'(CLK_HZ);

  if (256 * SAMPLE_HZ > CLK_HZ) begin : g_rate_chk
    $error("audio_i2s_tx: 256*SAMPLE_HZ exceeds CLK_HZ, BCLK cannot be generated");
  end

  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               bclk_q, bclk_d;
  logic [5:0]         n_q, n_d;
  logic               lrck_q, lrck_d;
  logic               sdata_q, sdata_d;
  logic               strobe_q, strobe_d;
  logic signed [15:0] left_q, left_d;
  logic signed [15:0] right_q, right_d;

  logic [ACC_W:0]     acc_sum;
  logic signed [15:0] ext_l, ext_r;
  logic signed [15:0] lat_l, lat_r;

  assign acc_sum = {1'b0, acc_q} + INC;
  assign ext_l   = {audio_left, 1'b0};
  assign ext_r   = {audio_right, 1'b0};

`ifdef AUDIO_I2S_CROSSFEED_EN
  // (3*a + b) >>> 2 in 18-bit signed arithmetic; the result always fits 16 bits.
  function automatic logic signed [15:0] crossfeed(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
    logic signed [17:0] a18;
    logic signed [17:0] b18;
    logic signed [17:0] s18;
    a18 = {{2{a[15]}}, a};
    b18 = {{2{b[15]}}, b};
    s18 = (a18 <<< 1) + a18 + b18;
    s18 = s18 >>> 2;
    return s18[15:0];
  endfunction

  assign lat_l = crossfeed(ext_l, ext_r);
  assign lat_r = crossfeed(ext_r, ext_l);
`else
  assign lat_l = ext_l;
  assign lat_r = ext_r;
`endif

  always_comb begin
    logic [4:0] slot;
    logic [3:0] bit_idx;
    logic signed [15:0] word;
    acc_d    = acc_sum[ACC_W-1:0];
    bclk_d   = bclk_q;
    n_d      = n_q;
    lrck_d   = lrck_q;
    sdata_d  = sdata_q;
    strobe_d = 1'b0;
    left_d   = left_q;
    right_d  = right_q;
    slot     = 5'd0;
    bit_idx  = 4'd0;
    word     = left_q;

    if (acc_sum >= LIM) begin
      acc_d  = ACC_W'(acc_sum - LIM);
      bclk_d = ~bclk_q;
      // Falling BCLK: advance the frame and present the next bit so it is
      // stable for the codec's rising-edge sample.
      if (bclk_q) begin
        n_d     = n_q + 6'd1;
        slot    = n_d[4:0];
        bit_idx = 4'(5'd16 - slot);
        word    = n_d[5] ? right_q : left_q;
        lrck_d  = n_d[5];
        sdata_d = ((slot >= 5'd1) && (slot <= 5'd16)) ? word[bit_idx] : 1'b0;
        // Slot 0 of the left word carries no data, so latching here cannot
        // disturb a word in flight.
        if (n_d == 6'd0) begin
          strobe_d = 1'b1;
          left_d   = mute ? 16'sd0 : lat_l;
          right_d  = mute ? 16'sd0 : lat_r;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      bclk_q   <= 1'b0;
      n_q      <= 6'd0;
      lrck_q   <= 1'b0;
      sdata_q  <= 1'b0;
      strobe_q <= 1'b0;
      left_q   <= 16'sd0;
      right_q  <= 16'sd0;
    end else begin
      acc_q    <= acc_d;
      bclk_q   <= bclk_d;
      n_q      <= n_d;
      lrck_q   <= lrck_d;
      sdata_q  <= sdata_d;
      strobe_q <= strobe_d;
      left_q   <= left_d;
      right_q  <= right_d;
    end
  end

  assign i2s_bclk      = bclk_q;
  assign i2s_lrck      = lrck_q;
  assign i2s_sdata     = sdata_q;
  assign sample_strobe = strobe_q;

endmodule
